icache_fill_ctrl: RTL and testbench

Direct-mapped instruction cache with miss-fill controller; the responder that serves the fetch stage's per-cycle instruction requests. Hits return the 16-bit instruction in the same cycle. Misses assert `icache_stall` so fetch holds its PC while an 8-word block is burst-filled from multi-cycle main memory through the memory arbiter. Sits between the fetch stage and the shared main-memory port.

---
 rtl/icache_pkg.sv | 24 ++
 rtl/icache_data_array.sv | 26 ++
 rtl/icache_fill_ctrl.sv | 151 +++++++++++++++
 tb/tb_icache_fill_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared geometry, field widths and fill FSM states
// for the direct-mapped instruction cache.
package icache_pkg;

  localparam int AW     = 16;
  localparam int DW     = 16;
  localparam int BLOCKS = 32;
  localparam int WORDS  = 8;
  localparam int OFF_W  = $clog2(WORDS);
  localparam int IDX_W  = $clog2(BLOCKS);
  localparam int TAG_W  = AW - IDX_W - OFF_W - 1;
  localparam int CNT_W  = 4;
  localparam int LINE_W = TAG_W + IDX_W;

  localparam logic [CNT_W-1:0] WORDS_C = CNT_W'(WORDS);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_GRANT,
    FILL
  } fill_state_e;

endpackage

// File: rtl/icache_data_array.sv
// Instruction cache data store: one write port and
// one combinational read port, storage is not reset.
module icache_data_array
  import icache_pkg::*;
(
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] widx,
  input  logic [OFF_W-1:0] wword,
  input  logic [DW-1:0]    wdata,
  input  logic [IDX_W-1:0] ridx,
  input  logic [OFF_W-1:0] rword,
  output logic [DW-1:0]    rdata
);

  logic [DW-1:0] mem_q [BLOCKS*WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[{widx, wword}] <= wdata;
    end
  end

  assign rdata = mem_q[{ridx, rword}];

endmodule

// File: rtl/icache_fill_ctrl.sv
// Direct-mapped icache: same-cycle hits, stall plus
// an 8-word burst fill from main memory on a miss.
module icache_fill_ctrl
  import icache_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          fetch_req,
  input  logic [AW-1:0] pc_addr,
  output logic [DW-1:0] instr,
  output logic          icache_stall,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_grant,
  input  logic          mem_data_valid,
  input  logic [DW-1:0] mem_data
);

  fill_state_e state_q, state_d;

  logic [TAG_W-1:0] fill_tag_q, fill_tag_d;
  logic [IDX_W-1:0] fill_idx_q, fill_idx_d;
  logic [CNT_W-1:0] issue_q, issue_d;
  logic [CNT_W-1:0] ret_q, ret_d;

  logic [BLOCKS-1:0] valid_q;
  logic [TAG_W-1:0]  tag_q [BLOCKS];

  logic [TAG_W-1:0] pc_tag;
  logic [IDX_W-1:0] pc_idx;
  logic [OFF_W-1:0] pc_word;
  logic             unused_pc_lsb;

  logic          hit;
  logic          ret_ok;
  logic          we;
  logic          line_done;
  logic [DW-1:0] rdata;

  assign pc_tag        = pc_addr[AW-1 -: TAG_W];
  assign pc_idx        = pc_addr[OFF_W+1 +: IDX_W];
  assign pc_word       = pc_addr[1 +: OFF_W];
  assign unused_pc_lsb = pc_addr[0];

  assign hit = fetch_req
             & valid_q[pc_idx]
             & (tag_q[pc_idx] == pc_tag);

  // Only accept returns for reads actually issued.
  assign ret_ok = mem_data_valid
                & (ret_q < issue_q);

  always_comb begin
    state_d      = state_q;
    fill_tag_d   = fill_tag_q;
    fill_idx_d   = fill_idx_q;
    issue_d      = issue_q;
    ret_d        = ret_q;
    mem_req      = 1'b0;
    icache_stall = 1'b0;
    we           = 1'b0;
    line_done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        icache_stall = fetch_req & ~hit;
        if (fetch_req && !hit) begin
          fill_tag_d = pc_tag;
          fill_idx_d = pc_idx;
          issue_d    = '0;
          ret_d      = '0;
          state_d    = WAIT_GRANT;
        end
      end
      WAIT_GRANT: begin
        icache_stall = 1'b1;
        mem_req      = 1'b1;
        if (mem_grant) begin
          issue_d = issue_q + 4'd1;
          state_d = FILL;
        end
      end
      FILL: begin
        icache_stall = 1'b1;
        mem_req      = (issue_q < WORDS_C);
        if (mem_req && mem_grant) begin
          issue_d = issue_q + 4'd1;
        end
        if (ret_ok) begin
          we    = 1'b1;
          ret_d = ret_q + 4'd1;
          if (ret_q == LAST_C) begin
            line_done = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    mem_addr = '0;
    if (mem_req) begin
      mem_addr = {fill_tag_q, fill_idx_q,
                  issue_q[OFF_W-1:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      fill_tag_q <= '0;
      fill_idx_q <= '0;
      issue_q    <= '0;
      ret_q      <= '0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      fill_tag_q <= fill_tag_d;
      fill_idx_q <= fill_idx_d;
      issue_q    <= issue_d;
      ret_q      <= ret_d;
      if (line_done) begin
        valid_q[fill_idx_q] <= 1'b1;
      end
    end
  end

  // Old tag stays live until the last word lands.
  always_ff @(posedge clk) begin
    if (line_done) begin
      tag_q[fill_idx_q] <= fill_tag_q;
    end
  end

  icache_data_array u_data (
    .clk   (clk),
    .we    (we),
    .widx  (fill_idx_q),
    .wword (ret_q[OFF_W-1:0]),
    .wdata (mem_data),
    .ridx  (pc_idx),
    .rword (pc_word),
    .rdata (rdata)
  );

  assign instr = (state_q == IDLE && hit) ? rdata : '0;

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Directed bench for icache_fill_ctrl with a
// fixed-latency memory model behind the arbiter.
module tb_icache_fill_ctrl;

  logic        clk;
  logic        rst;
  logic        fetch_req;
  logic [15:0] pc_addr;
  logic [15:0] instr;
  logic        icache_stall;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_grant;
  logic        mem_data_valid;
  logic [15:0] mem_data;

  typedef struct {
    int          due;
    logic [15:0] addr;
  } rd_t;

  rd_t         pend[$];
  logic [15:0] issued[$];
  logic [15:0] held_addr;
  logic        stray_en;
  int          cyc;
  int          lat;
  int          gnt_block;
  int          ncmp;
  int          nerr;
  int          s;

  icache_fill_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_req      (fetch_req),
    .pc_addr        (pc_addr),
    .instr          (instr),
    .icache_stall   (icache_stall),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_grant      (mem_grant),
    .mem_data_valid (mem_data_valid),
    .mem_data       (mem_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return 16'h1000 + {1'b0, a[15:1]};
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic setup(input logic fr,
                       input logic [15:0] pc);
    fetch_req = fr;
    pc_addr   = pc;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      mem_data_valid = 1'b1;
      mem_data       = mem_word(pend[0].addr);
      void'(pend.pop_front());
    end else if (stray_en) begin
      mem_data_valid = 1'b1;
      mem_data       = 16'hDEAD;
    end else begin
      mem_data_valid = 1'b0;
      mem_data       = 16'h0000;
    end
    #1;
    mem_grant = mem_req && (gnt_block == 0);
    #1;
  endtask

  task automatic tick();
    if (mem_req && mem_grant) begin
      pend.push_back('{cyc + lat, mem_addr});
      issued.push_back(mem_addr);
    end
    if (mem_req && !mem_grant) begin
      held_addr = mem_addr;
      if (gnt_block > 0) gnt_block--;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic fetch(input logic [15:0] pc,
                       output int stalls);
    stalls = 0;
    for (int i = 0; i < 200; i++) begin
      setup(1'b1, pc);
      if (!icache_stall) return;
      stalls++;
      tick();
    end
    check("fetch_timeout", 32'(icache_stall), 0);
  endtask

  initial begin
    rst            = 1'b0;
    fetch_req      = 1'b0;
    pc_addr        = 16'h0000;
    mem_grant      = 1'b0;
    mem_data_valid = 1'b0;
    mem_data       = 16'h0000;
    stray_en       = 1'b0;
    held_addr      = 16'h0000;
    cyc            = 0;
    lat            = 4;
    gnt_block      = 0;
    ncmp           = 0;
    nerr           = 0;

    @(negedge clk);
    setup(1'b0, 16'h0000);
    check("rst_stall", 32'(icache_stall), 0);
    check("rst_instr", 32'(instr), 0);
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    tick();
    tick();
    rst = 1'b1;
    tick();

    // cold miss
    issued.delete();
    fetch(16'h0000, s);
    check("cold_stalls", 32'(s), 13);
    check("cold_instr", 32'(instr), 'h1000);
    check("cold_nissued", 32'(issued.size()), 8);
    for (int n = 0; n < 8; n++) begin
      check("cold_mem_addr", 32'(issued[n]), 32'(2 * n));
    end
    tick();

    // sequential hits
    for (int n = 1; n < 8; n++) begin
      fetch(16'(2 * n), s);
      check("seq_stalls", 32'(s), 0);
      check("seq_instr", 32'(instr), 32'('h1000 + n));
      tick();
    end

    // no request, no miss
    setup(1'b0, 16'h0400);
    check("noreq_stall", 32'(icache_stall), 0);
    check("noreq_instr", 32'(instr), 0);
    tick();
    setup(1'b0, 16'h0400);
    check("noreq_mem_req", 32'(mem_req), 0);
    tick();

    // conflict miss on index 0
    fetch(16'h0200, s);
    check("conf_stalls", 32'(s), 13);
    check("conf_instr", 32'(instr), 'h1100);
    tick();
    fetch(16'h0000, s);
    check("conf_back_stalls", 32'(s), 13);
    check("conf_back_instr", 32'(instr), 'h1000);
    tick();

    // three-cycle grant gap
    gnt_block = 3;
    held_addr = 16'hFFFF;
    fetch(16'h0040, s);
    check("gap_stalls", 32'(s), 16);
    check("gap_held_addr", 32'(held_addr), 'h0040);
    check("gap_instr", 32'(instr), 'h1020);
    tick();

    // fetch flush mid-fill
    fetch(16'h0200, s);
    check("flush_pre_instr", 32'(instr), 'h1100);
    tick();
    for (int i = 0; i < 5; i++) begin
      setup(1'b1, 16'h0000);
      check("flush_miss_stall", 32'(icache_stall), 1);
      tick();
    end
    fetch(16'h0120, s);
    check("flush_stalls", 32'(s), 21);
    check("flush_instr", 32'(instr), 'h1090);
    tick();
    fetch(16'h0000, s);
    check("flush_line0_stalls", 32'(s), 0);
    check("flush_line0_instr", 32'(instr), 'h1000);
    tick();

    // reset during fill after word 4 returned
    for (int i = 0; i < 10; i++) begin
      setup(1'b1, 16'h0200);
      tick();
    end
    rst = 1'b0;
    setup(1'b0, 16'h0000);
    check("mrst_mem_req", 32'(mem_req), 0);
    check("mrst_stall", 32'(icache_stall), 0);
    check("mrst_instr", 32'(instr), 0);
    check("mrst_mem_addr", 32'(mem_addr), 0);
    tick();
    setup(1'b0, 16'h0000);
    tick();
    rst = 1'b1;
    stray_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      setup(1'b0, 16'h0000);
      tick();
    end
    stray_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      setup(1'b0, 16'h0000);
      check("mrst_idle_req", 32'(mem_req), 0);
      tick();
    end
    issued.delete();
    fetch(16'h0000, s);
    check("mrst_refill_stalls", 32'(s), 13);
    check("mrst_refill_instr", 32'(instr), 'h1000);
    check("mrst_refill_n", 32'(issued.size()), 8);
    tick();
    fetch(16'h0200, s);
    check("mrst_other_stalls", 32'(s), 13);
    check("mrst_other_instr", 32'(instr), 'h1100);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
